subbytes_sched: RTL and testbench
=================================

Name: subbytes_sched

Overview:
- Sequences a 32-bit, four-S-box SubBytes lane over full 128-bit AES states, replacing the 16-S-box parallel array.
- Shares the same lane with the key-expansion SubWord requester.
- Sits between the round-control FSM and the key-schedule FSM.
- Trades 3 extra cycles per round for 12 fewer sbox instances.

Parameters:
KEY_FIRST, 1, when both requesters are valid in IDLE: 1 = the key word wins, 0 = the state wins.
STARVE_LIMIT, 2, number of consecutive key grants while st_valid is held, after which the state request is granted next (range 1..7).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
st_valid  input  1  state request valid
st_ready  output  1  state request accepted when st_valid && st_ready
st_data  input  128  state; column c = st_data[127-32c -: 32], c = 0..3
st_out_valid  output  1  one-cycle pulse, st_out valid
st_out  output  128  SubBytes(st_data), same byte layout
kw_valid  input  1  key-word request valid
kw_ready  output  1  key-word accepted when kw_valid && kw_ready
kw_data  input  32  word to substitute (RotWord already applied by the requester)
kw_out_valid  output  1  one-cycle pulse, kw_out valid
kw_out  output  32  SubWord(kw_data)
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values (all outputs and state):
  - st_ready = 0, kw_ready = 0, st_out_valid = 0, kw_out_valid = 0, busy = 0.
  - st_out = 0, kw_out = 0.
  - FSM = IDLE, beat counter = 0, starve counter = 0.
- The lane is 4 sbox instances. Lane input byte i = lane_in[31-8i -: 8].
- FSM states: IDLE, ST_RUN, KW_RUN.
- IDLE, ready generation (combinational from FSM, valids and counters):
  - If only one requester is valid, its ready is high.
  - If both are valid, the winner is chosen as follows:
    - the state wins if starve counter == STARVE_LIMIT;
    - otherwise the key word wins if KEY_FIRST = 1, else the state wins.
  - The losing requester's ready is low.
  - st_ready and kw_ready are never high together.
  - Outside IDLE, both readies are low.
- State accept at cycle T:
  - st_data is captured and the FSM moves to ST_RUN with beat = 0.
  - In cycles T+1..T+4, beat b drives column b into the lane and writes the result to st_out column b.
  - The beat counter is 2 bits and wraps 3 -> 0.
  - On beat 3 the FSM returns to IDLE.
  - st_out_valid pulses at T+5. st_out holds its value until the next state completion.
  - st_ready may be high at T+5, so back-to-back states run at one every 5 cycles.
- Key accept at cycle T:
  - kw_data is captured and the FSM moves to KW_RUN.
  - The lane is driven at T+1 and the FSM returns to IDLE.
  - kw_out_valid pulses at T+2. kw_out holds its value.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on a key grant while st_valid is high.
  - Clears on any state grant, or on any cycle in IDLE with st_valid low.
- Lane mux default: when neither ST_RUN nor KW_RUN is active, the lane input is 0. No output changes.
- A request arriving while busy is not accepted. The requester must hold valid and data stable until accepted.
- Reset mid-operation: the in-flight operation is discarded, no completion pulse is issued, and all reset values are restored on the next edge.
- There is no output backpressure. Consumers must sample on the valid pulse.

Optional Feature:
SUBBYTES_SCHED_PIPE_EN
- Defined:
  - A 32-bit register is inserted between the lane output and the writeback, with its column index or key tag registered alongside.
  - Beats still issue every cycle.
  - State completion moves to T+6 and key completion to T+3.
  - The FSM leaves ST_RUN/KW_RUN only when the last writeback is done, so readies return one cycle later.
  - Reset clears the pipeline register and its tag.
- Undefined: the lane is combinational into the writeback, with the latencies given in Behaviour.

Decomposition:
- Shared package aes_pkg holds:
  - the state type (128 bits) and word type (32 bits);
  - the FSM state enum;
  - the constant NUM_COLS = 4.
- Natural sub-module: subword_lane, four existing sbox instances mapping 32 -> 32, purely combinational.
- The scheduler contains only the FSM, the counters, the capture register, the output registers and the optional pipeline register.

Test Plan:
1. State only: st_data = 193de3bea0f4e22b9ac68d2ae9f84808 accepted at T -> st_out_valid at T+5 (T+6 with PIPE_EN), st_out = d42711aee0bf98f1b8b45de51e415230, busy high T+1..T+4.
2. Key only: kw_data = cf4f3c09 -> kw_out_valid at T+2, kw_out = 8a84eb01. Also kw_data = 00000000 -> 63636363.
3. Simultaneous request, KEY_FIRST = 1: kw_ready high, st_ready low. The key completes, then the state is accepted at the next IDLE cycle, and both results are correct.
4. Starvation with KEY_FIRST = 1, STARVE_LIMIT = 2: kw_valid and st_valid held continuously -> key, key, state, key, key, state grant pattern; starve counter clears on each state grant.
5. Reset mid-operation: rst asserted at T+2 of a state op -> no st_out_valid pulse, st_out = 0, FSM IDLE. A following request completes normally.
6. Back-to-back states: four states submitted with st_valid held -> st_out_valid at T+5, T+10, T+15, T+20 with correct values, and no ready while busy.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types for the SubBytes/SubWord scheduler: 128-bit state, 32-bit word,
// column count and the scheduler FSM encoding.
// Column c of a state occupies bits [127-32c -: 32]; state_t index 0 is the top word.
package aes_pkg;

    localparam int NUM_COLS = 4;

    typedef logic [31:0] word_t;

    // Packed with ascending column index so that column 0 lands in bits 127:96.
    typedef logic [0:NUM_COLS-1][31:0] state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        KW_RUN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/sbox.sv
// AES forward S-box, one byte in, one byte out, purely combinational.
// Ports: a = input byte, y = substituted byte.
// Table lookup; synthesis maps it to logic.
module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/subword_lane.sv
// 32-bit SubWord lane: four S-boxes side by side, purely combinational.
// Ports: lane_in = word to substitute, lane_out = substituted word.
// Byte i of the lane is bits [31-8i -: 8] on both sides.
module subword_lane
    import aes_pkg::*;
(
    input  word_t lane_in,
    output word_t lane_out
);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sbox u_sbox (
            .a (lane_in[31-8*i -: 8]),
            .y (lane_out[31-8*i -: 8])
        );
    end

endmodule

// File: rtl/subbytes_sched.sv
// Time-shares one 4-S-box lane between full-state SubBytes (4 beats) and key SubWord (1 beat).
// Ports: st_* state request/result, kw_* key-word request/result, busy = FSM not IDLE.
// Optional SUBBYTES_SCHED_PIPE_EN adds a register after the lane (+1 cycle latency each op).
module subbytes_sched
    import aes_pkg::*;
#(
    parameter bit          KEY_FIRST    = 1'b1,
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_data,
    output logic         st_out_valid,
    output logic [127:0] st_out,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [31:0]  kw_data,
    output logic         kw_out_valid,
    output logic [31:0]  kw_out,
    output logic         busy
);

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    sched_state_e state_q, state_d;
    logic [1:0]   beat_q;
    logic [2:0]   starve_q;
    state_t       cap_q;
    word_t        lane_in, lane_out;
    logic         st_win, st_go, kw_go;
    logic         issue_st, issue_kw;
    logic         wb_vld, wb_key, done;
    logic [1:0]   wb_col;
    word_t        wb_dat;

    subword_lane u_lane (
        .lane_in  (lane_in),
        .lane_out (lane_out)
    );

    // State wins a tie once it has been passed over STARVE_LIMIT times in a row.
    assign st_win = (starve_q == STARVE_MAX) || !KEY_FIRST;
    assign st_go  = st_valid && st_ready;
    assign kw_go  = kw_valid && kw_ready;
    assign busy   = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        st_ready = 1'b0;
        kw_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst) begin
                    st_ready = st_valid && (!kw_valid || st_win);
                    kw_ready = kw_valid && (!st_valid || !st_win);
                end
                if (st_valid && st_ready) begin
                    state_d = ST_RUN;
                end else if (kw_valid && kw_ready) begin
                    state_d = KW_RUN;
                end
            end
            ST_RUN, KW_RUN: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SUBBYTES_SCHED_PIPE_EN
    // Lane result is registered with its column/key tag; the FSM waits in the
    // run state for that last registered beat (drain) before going IDLE.
    logic       drain_q;
    logic       p_vld, p_key;
    logic [1:0] p_col;
    word_t      p_dat;

    assign issue_st = (state_q == ST_RUN) && !drain_q;
    assign issue_kw = (state_q == KW_RUN) && !drain_q;
    assign wb_vld   = p_vld;
    assign wb_key   = p_key;
    assign wb_col   = p_col;
    assign wb_dat   = p_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_q <= 1'b0;
            p_vld   <= 1'b0;
            p_key   <= 1'b0;
            p_col   <= 2'd0;
            p_dat   <= '0;
        end else begin
            p_vld <= issue_st || issue_kw;
            if (issue_st || issue_kw) begin
                p_key <= issue_kw;
                p_col <= beat_q;
                p_dat <= lane_out;
            end
            if (done) begin
                drain_q <= 1'b0;
            end else if (issue_kw || (issue_st && beat_q == 2'd3)) begin
                drain_q <= 1'b1;
            end
        end
    end
`else
    assign issue_st = (state_q == ST_RUN);
    assign issue_kw = (state_q == KW_RUN);
    assign wb_vld   = issue_st || issue_kw;
    assign wb_key   = issue_kw;
    assign wb_col   = beat_q;
    assign wb_dat   = lane_out;
`endif

    // Operation finishes when its final result reaches the output registers.
    assign done = wb_vld && (wb_key || wb_col == 2'd3);

    always_comb begin
        lane_in = '0;
        if (issue_st) begin
            lane_in = cap_q[beat_q];
        end else if (issue_kw) begin
            lane_in = cap_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= 2'd0;
            starve_q     <= 3'd0;
            cap_q        <= '0;
            st_out       <= '0;
            kw_out       <= '0;
            st_out_valid <= 1'b0;
            kw_out_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            st_out_valid <= 1'b0;
            kw_out_valid <= 1'b0;

            if (st_go) begin
                cap_q <= st_data;
            end else if (kw_go) begin
                cap_q[0] <= kw_data;
            end

            if (issue_st) begin
                beat_q <= beat_q + 2'd1;
            end

            if (state_q == IDLE) begin
                if (st_go || !st_valid) begin
                    starve_q <= 3'd0;
                end else if (kw_go && starve_q != STARVE_MAX) begin
                    starve_q <= starve_q + 3'd1;
                end
            end

            // Columns 0..2 are parked back in the (already consumed) capture
            // slots so st_out only changes, all at once, on completion.
            if (wb_vld) begin
                if (wb_key) begin
                    kw_out       <= wb_dat;
                    kw_out_valid <= 1'b1;
                end else if (wb_col == 2'd3) begin
                    st_out       <= {cap_q[0], cap_q[1], cap_q[2], wb_dat};
                    st_out_valid <= 1'b1;
                end else begin
                    cap_q[wb_col] <= wb_dat;
                end
            end
        end
    end

endmodule

// File: tb/tb_subbytes_sched.sv
// Self-checking bench for subbytes_sched: reset values, table of directed
// state/key vectors, arbitration, starvation, mid-op reset, back-to-back states.
// Latencies follow SUBBYTES_SCHED_PIPE_EN when it is defined.
module tb_subbytes_sched;

`ifdef SUBBYTES_SCHED_PIPE_EN
    localparam int ST_LAT = 6;
    localparam int KW_LAT = 3;
`else
    localparam int ST_LAT = 5;
    localparam int KW_LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         st_valid, st_ready, st_out_valid;
    logic [127:0] st_data, st_out;
    logic         kw_valid, kw_ready, kw_out_valid;
    logic [31:0]  kw_data, kw_out;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        bit           is_key;
        logic [127:0] din;
        logic [127:0] dout;
        string        nm;
    } vec_t;

    vec_t tbl [6];

    subbytes_sched #(.KEY_FIRST(1'b1), .STARVE_LIMIT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_data      (st_data),
        .st_out_valid (st_out_valid),
        .st_out       (st_out),
        .kw_valid     (kw_valid),
        .kw_ready     (kw_ready),
        .kw_data      (kw_data),
        .kw_out_valid (kw_out_valid),
        .kw_out       (kw_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, got, exp);
    endtask

    task automatic wait_valid(input bit key, input int budget, output int waited);
        waited = 0;
        while (waited < budget && !(key ? kw_out_valid : st_out_valid)) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Called at a negedge with the FSM idle; returns at the negedge of T+lat.
    task automatic do_op(input vec_t v);
        int lat;
        bit early;
        lat = v.is_key ? KW_LAT : ST_LAT;
        if (v.is_key) begin
            kw_valid = 1'b1; kw_data = v.din[31:0];
        end else begin
            st_valid = 1'b1; st_data = v.din;
        end
        #1;
        chk({v.nm, "_ready"}, v.is_key ? kw_ready : st_ready, 1);
        @(posedge clk);
        @(negedge clk);
        st_valid = 1'b0;
        kw_valid = 1'b0;
        chk({v.nm, "_busy_t1"}, busy, 1);
        early = 1'b0;
        for (int k = 1; k < lat; k++) begin
            if (st_out_valid || kw_out_valid) early = 1'b1;
            @(negedge clk);
        end
        chk({v.nm, "_early_pulse"}, early, 0);
        chk({v.nm, "_valid"}, v.is_key ? kw_out_valid : st_out_valid, 1);
        chk({v.nm, "_data"}, v.is_key ? {96'd0, kw_out} : st_out, v.dout);
        chk({v.nm, "_busy_done"}, busy, 0);
    endtask

    int           w, ng, n_acc, n_out, t0;
    bit           both, seen, prev_acc, busy_rdy;
    bit           grants [6];
    bit           exp_grants [6];
    int           out_cyc [4];
    logic [127:0] bb_in [4];
    logic [127:0] bb_exp [4];

    initial begin
        tbl[0] = '{1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, "st_fips"};
        tbl[1] = '{1'b1, 128'hcf4f3c09, 128'h8a84eb01, "kw_fips"};
        tbl[2] = '{1'b1, 128'h00000000, 128'h63636363, "kw_zero"};
        tbl[3] = '{1'b0, 128'h0, {16{8'h63}}, "st_zero"};
        tbl[4] = '{1'b1, 128'hffffffff, 128'h16161616, "kw_ones"};
        tbl[5] = '{1'b0, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816, "st_diag"};
        exp_grants = '{0, 0, 1, 0, 0, 1};

        // Reset: readies stay low even with both valids asserted.
        rst = 1'b1; st_valid = 1'b1; kw_valid = 1'b1;
        st_data = tbl[0].din; kw_data = 32'hcf4f3c09;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_st_ready", st_ready, 0);
        chk("rst_kw_ready", kw_ready, 0);
        chk("rst_st_out_valid", st_out_valid, 0);
        chk("rst_kw_out_valid", kw_out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_st_out", st_out, 0);
        chk("rst_kw_out", kw_out, 0);
        rst = 1'b0; st_valid = 1'b0; kw_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) do_op(tbl[i]);

        // Simultaneous request: key wins, state follows at the next idle cycle.
        st_valid = 1'b1; st_data = tbl[0].din;
        kw_valid = 1'b1; kw_data = 32'hcf4f3c09;
        #1;
        chk("sim_kw_ready", kw_ready, 1);
        chk("sim_st_ready", st_ready, 0);
        @(negedge clk);
        kw_valid = 1'b0;
        wait_valid(1'b1, 10, w);
        chk("sim_kw_latency", w, KW_LAT - 1);
        chk("sim_kw_data", kw_out, 32'h8a84eb01);
        chk("sim_st_ready_after_kw", st_ready, 1);
        @(negedge clk);
        st_valid = 1'b0;
        wait_valid(1'b0, 20, w);
        chk("sim_st_latency", w, ST_LAT - 1);
        chk("sim_st_data", st_out, tbl[0].dout);
        repeat (3) @(negedge clk);

        // Starvation: both held, grants must go K K S K K S.
        st_valid = 1'b1; kw_valid = 1'b1;
        st_data = tbl[5].din; kw_data = 32'h00000000;
        ng = 0; both = 1'b0;
        for (int c = 0; c < 200 && ng < 6; c++) begin
            #1;
            if (st_ready && kw_ready) both = 1'b1;
            if (kw_ready) begin grants[ng] = 1'b0; ng++; end
            else if (st_ready) begin grants[ng] = 1'b1; ng++; end
            @(negedge clk);
        end
        st_valid = 1'b0; kw_valid = 1'b0;
        chk("starve_grant_count", ng, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("starve_grant%0d", i), grants[i], exp_grants[i]);
        chk("starve_both_ready", both, 0);
        repeat (10) @(negedge clk);

        // Reset at T+2 of a state op: no pulse, outputs cleared.
        st_valid = 1'b1; st_data = tbl[0].din;
        #1;
        chk("mrst_accept", st_ready, 1);
        @(negedge clk);
        st_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy_after", busy, 0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (st_out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("mrst_no_pulse", seen, 0);
        chk("mrst_st_out", st_out, 0);
        do_op(tbl[5]);

        // Back-to-back states with st_valid held.
        bb_in[0] = tbl[0].din; bb_exp[0] = tbl[0].dout;
        bb_in[1] = tbl[3].din; bb_exp[1] = tbl[3].dout;
        bb_in[2] = tbl[5].din; bb_exp[2] = tbl[5].dout;
        bb_in[3] = {16{8'hff}}; bb_exp[3] = {16{8'h16}};
        n_acc = 0; n_out = 0; prev_acc = 1'b0; busy_rdy = 1'b0; t0 = 0;
        @(negedge clk);
        for (int c = 0; c < 200 && n_out < 4; c++) begin
            if (st_out_valid) begin
                out_cyc[n_out] = cyc;
                chk($sformatf("b2b_data%0d", n_out), st_out, bb_exp[n_out]);
                n_out++;
            end
            if (prev_acc) n_acc++;
            st_valid = (n_acc < 4);
            if (n_acc < 4) st_data = bb_in[n_acc];
            #1;
            if (busy && st_ready) busy_rdy = 1'b1;
            prev_acc = st_valid && st_ready;
            if (prev_acc && n_acc == 0) t0 = cyc;
            @(negedge clk);
        end
        st_valid = 1'b0;
        chk("b2b_out_count", n_out, 4);
        for (int i = 0; i < n_out; i++)
            chk($sformatf("b2b_cycle%0d", i), out_cyc[i] - t0, ST_LAT * (i + 1));
        chk("b2b_ready_while_busy", busy_rdy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
